// File: rtl/pcileech_cfgspace_arb_pkg.sv
// Shared types and constants for the shadow config-space BRAM request arbiter.
package pcileech_cfgspace_arb_pkg;

  // Source type driven on bram_tp for every issued request.
  localparam logic [1:0] SRC_IDLE = 2'b00;
  localparam logic [1:0] SRC_TLP  = 2'b01;
  localparam logic [1:0] SRC_USB  = 2'b10;
  localparam logic [1:0] SRC_INT  = 2'b11;

  // One queued or candidate BRAM request.
  typedef struct packed {
    logic        wr;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  tag;
    logic [15:0] reqid;
  } cfgarb_req_t;

  // Byte enables only survive on writes; reads always issue with be = 0.
  function automatic logic [3:0] cfgarb_be_gate(input logic wr, input logic [3:0] be);
    return wr ? be : 4'b0000;
  endfunction

endpackage

// File: rtl/pcileech_cfgspace_arbiter_if.sv
// Request and issue bus of the config-space arbiter. The requester side
// (TLP/USB/internal sources) uses master; the arbiter uses slave.
interface pcileech_cfgspace_arbiter_if;

  logic        cfgtlp_wren;

  logic        tlp_req_valid;
  logic        tlp_req_wr;
  logic [9:0]  tlp_req_addr;
  logic [3:0]  tlp_req_be;
  logic [31:0] tlp_req_data;
  logic [7:0]  tlp_req_tag;
  logic [15:0] tlp_req_reqid;

  logic        usb_req_valid;
  logic        usb_req_wr;
  logic        usb_req_addr_lo;
  logic [9:0]  usb_req_addr;
  logic [3:0]  usb_req_be;
  logic [31:0] usb_req_data;

  logic        int_req_valid;
  logic        int_req_ready;
  logic        int_req_wr;
  logic [9:0]  int_req_addr;
  logic [3:0]  int_req_be;
  logic [31:0] int_req_data;

  logic [9:0]  bram_addr;
  logic [3:0]  bram_wr_be;
  logic [31:0] bram_wr_data;
  logic [7:0]  bram_tag;
  logic [1:0]  bram_tp;
  logic [15:0] bram_reqid;
  logic        bram_tlpwr;

  logic        tlp_ovf;
  logic        usb_ovf;

  modport master (
    output cfgtlp_wren,
    output tlp_req_valid, tlp_req_wr, tlp_req_addr, tlp_req_be, tlp_req_data,
           tlp_req_tag, tlp_req_reqid,
    output usb_req_valid, usb_req_wr, usb_req_addr_lo, usb_req_addr, usb_req_be,
           usb_req_data,
    output int_req_valid, int_req_wr, int_req_addr, int_req_be, int_req_data,
    input  int_req_ready,
    input  bram_addr, bram_wr_be, bram_wr_data, bram_tag, bram_tp, bram_reqid,
           bram_tlpwr,
    input  tlp_ovf, usb_ovf
  );

  modport slave (
    input  cfgtlp_wren,
    input  tlp_req_valid, tlp_req_wr, tlp_req_addr, tlp_req_be, tlp_req_data,
           tlp_req_tag, tlp_req_reqid,
    input  usb_req_valid, usb_req_wr, usb_req_addr_lo, usb_req_addr, usb_req_be,
           usb_req_data,
    input  int_req_valid, int_req_wr, int_req_addr, int_req_be, int_req_data,
    output int_req_ready,
    output bram_addr, bram_wr_be, bram_wr_data, bram_tag, bram_tp, bram_reqid,
           bram_tlpwr,
    output tlp_ovf, usb_ovf
  );

endinterface

// File: rtl/pcileech_cfgspace_req_fifo.sv
// Small synchronous request FIFO. The head is visible the cycle after a push
// into an empty queue; a push into a full queue is accepted only when the
// same cycle pops.
module pcileech_cfgspace_req_fifo
  import pcileech_cfgspace_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  cfgarb_req_t push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output cfgarb_req_t head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cfgarb_req_t      mem_q [DEPTH];
  cfgarb_req_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             accept;
  logic             do_pop;

  assign full  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Next pointer/count/storage state from accepted pushes and pops.
  always_comb begin
    accept   = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (accept) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({accept, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the queue is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pcileech_cfgspace_arbiter.sv
// Arbiter/scheduler for the shadow config-space BRAM request port. Queues
// TLP and USB requests, accepts internal requests by valid/ready, grants one
// request per cycle and inserts a bubble on the BRAM read-modify-write hazard.
module pcileech_cfgspace_arbiter
  import pcileech_cfgspace_arb_pkg::*;
#(
  parameter int unsigned TLP_DEPTH  = 2,
  parameter int unsigned USB_DEPTH  = 4,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic                         clk_pcie,
  input  logic                         rst,
  pcileech_cfgspace_arbiter_if.slave   bus
);

  cfgarb_req_t tlp_in, usb_in, int_in;
  cfgarb_req_t tlp_head, usb_head, cand;
  logic        tlp_full, tlp_empty, tlp_pop;
  logic        usb_full, usb_empty, usb_pop;
  logic [1:0]  cand_src;
  logic        int_starved, hazard, grant, int_grant;

  logic [3:0]  int_age_q, int_age_d;
  logic [9:0]  bram_addr_q, bram_addr_d;
  logic [3:0]  bram_wr_be_q, bram_wr_be_d;
  logic [31:0] bram_wr_data_q, bram_wr_data_d;
  logic [7:0]  bram_tag_q, bram_tag_d;
  logic [1:0]  bram_tp_q, bram_tp_d;
  logic [15:0] bram_reqid_q, bram_reqid_d;
  logic        bram_tlpwr_q, bram_tlpwr_d;
  logic        tlp_ovf_q, tlp_ovf_d;
  logic        usb_ovf_q, usb_ovf_d;

  // USB requests carry the address low bit in the tag; internal requests
  // carry no tag or requester id.
  assign tlp_in = '{wr: bus.tlp_req_wr, addr: bus.tlp_req_addr, be: bus.tlp_req_be,
                    data: bus.tlp_req_data, tag: bus.tlp_req_tag,
                    reqid: bus.tlp_req_reqid};
  assign usb_in = '{wr: bus.usb_req_wr, addr: bus.usb_req_addr, be: bus.usb_req_be,
                    data: bus.usb_req_data, tag: {7'h00, bus.usb_req_addr_lo},
                    reqid: 16'h0000};
  assign int_in = '{wr: bus.int_req_wr, addr: bus.int_req_addr, be: bus.int_req_be,
                    data: bus.int_req_data, tag: 8'h00, reqid: 16'h0000};

  pcileech_cfgspace_req_fifo #(.DEPTH(TLP_DEPTH)) u_tlp_fifo (
    .clk       (clk_pcie),
    .rst       (rst),
    .push      (bus.tlp_req_valid),
    .push_data (tlp_in),
    .pop       (tlp_pop),
    .full      (tlp_full),
    .empty     (tlp_empty),
    .head      (tlp_head)
  );

  pcileech_cfgspace_req_fifo #(.DEPTH(USB_DEPTH)) u_usb_fifo (
    .clk       (clk_pcie),
    .rst       (rst),
    .push      (bus.usb_req_valid),
    .push_data (usb_in),
    .pop       (usb_pop),
    .full      (usb_full),
    .empty     (usb_empty),
    .head      (usb_head)
  );

  // Candidate selection, hazard compare and grant decode.
  always_comb begin
    int_starved = bus.int_req_valid && (32'(int_age_q) >= STARVE_MAX);
    cand_src    = SRC_IDLE;
    cand        = '0;
    if (!tlp_empty) begin
      cand_src = SRC_TLP;
      cand     = tlp_head;
    end else if (int_starved) begin
      cand_src = SRC_INT;
      cand     = int_in;
    end else if (!usb_empty) begin
      cand_src = SRC_USB;
      cand     = usb_head;
    end else if (bus.int_req_valid) begin
      cand_src = SRC_INT;
      cand     = int_in;
    end
    // The BRAM write path is read-modify-write, so any access (read or write)
    // to the address of an in-flight enabled write must wait one cycle.
    hazard    = (bram_wr_be_q != 4'b0000) && (cand.addr == bram_addr_q);
    grant     = (cand_src != SRC_IDLE) && !hazard && !rst;
    tlp_pop   = grant && (cand_src == SRC_TLP);
    usb_pop   = grant && (cand_src == SRC_USB);
    int_grant = grant && (cand_src == SRC_INT);
  end

  assign bus.int_req_ready = int_grant;

  // Internal-requester wait age, saturating at 15.
  always_comb begin
    int_age_d = int_age_q;
    if (!bus.int_req_valid || int_grant) begin
      int_age_d = '0;
    end else if (int_age_q != 4'hF) begin
      int_age_d = int_age_q + 4'd1;
    end
  end

  // Next output-register contents and sticky overflow flags.
  always_comb begin
    bram_addr_d    = '0;
    bram_wr_be_d   = '0;
    bram_wr_data_d = '0;
    bram_tag_d     = '0;
    bram_tp_d      = SRC_IDLE;
    bram_reqid_d   = '0;
    bram_tlpwr_d   = 1'b0;
    if (grant) begin
      bram_addr_d    = cand.addr;
      bram_wr_data_d = cand.data;
      bram_tag_d     = cand.tag;
      bram_reqid_d   = cand.reqid;
      bram_tp_d      = cand_src;
      if (cand_src == SRC_TLP) begin
        bram_wr_be_d = cfgarb_be_gate(cand.wr && bus.cfgtlp_wren, cand.be);
        bram_tlpwr_d = cand.wr;
      end else begin
        bram_wr_be_d = cfgarb_be_gate(cand.wr, cand.be);
      end
    end
    tlp_ovf_d = tlp_ovf_q || (bus.tlp_req_valid && tlp_full && !tlp_pop);
    usb_ovf_d = usb_ovf_q || (bus.usb_req_valid && usb_full && !usb_pop);
  end

  // Registered outputs, age counter and overflow flags.
  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      int_age_q      <= '0;
      bram_addr_q    <= '0;
      bram_wr_be_q   <= '0;
      bram_wr_data_q <= '0;
      bram_tag_q     <= '0;
      bram_tp_q      <= SRC_IDLE;
      bram_reqid_q   <= '0;
      bram_tlpwr_q   <= 1'b0;
      tlp_ovf_q      <= 1'b0;
      usb_ovf_q      <= 1'b0;
    end else begin
      int_age_q      <= int_age_d;
      bram_addr_q    <= bram_addr_d;
      bram_wr_be_q   <= bram_wr_be_d;
      bram_wr_data_q <= bram_wr_data_d;
      bram_tag_q     <= bram_tag_d;
      bram_tp_q      <= bram_tp_d;
      bram_reqid_q   <= bram_reqid_d;
      bram_tlpwr_q   <= bram_tlpwr_d;
      tlp_ovf_q      <= tlp_ovf_d;
      usb_ovf_q      <= usb_ovf_d;
    end
  end

  assign bus.bram_addr    = bram_addr_q;
  assign bus.bram_wr_be   = bram_wr_be_q;
  assign bus.bram_wr_data = bram_wr_data_q;
  assign bus.bram_tag     = bram_tag_q;
  assign bus.bram_tp      = bram_tp_q;
  assign bus.bram_reqid   = bram_reqid_q;
  assign bus.bram_tlpwr   = bram_tlpwr_q;
  assign bus.tlp_ovf      = tlp_ovf_q;
  assign bus.usb_ovf      = usb_ovf_q;

endmodule

// File: tb/tb_pcileech_cfgspace_arbiter.sv
// Self-checking bench for pcileech_cfgspace_arbiter: scenario tasks drive
// requests, push expected issued requests to a scoreboard queue and compare
// them against what the output register actually issues.
module tb_pcileech_cfgspace_arbiter;
  import pcileech_cfgspace_arb_pkg::*;

  typedef struct packed {
    logic [1:0]  tp;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  tag;
    logic [15:0] reqid;
    logic        tlpwr;
  } out_t;

  logic clk_pcie = 1'b0;
  logic rst      = 1'b1;
  always #5 clk_pcie = ~clk_pcie;

  pcileech_cfgspace_arbiter_if bus();

  pcileech_cfgspace_arbiter #(.TLP_DEPTH(2), .USB_DEPTH(4), .STARVE_MAX(15)) dut (
    .clk_pcie (clk_pcie),
    .rst      (rst),
    .bus      (bus)
  );

  int   checks = 0;
  int   passed = 0;
  out_t exp_q[$];
  out_t obs_q[$];
  out_t mon;

  // Record every non-bubble issued request.
  always @(negedge clk_pcie) begin
    if (bus.bram_tp != SRC_IDLE) begin
      mon = {bus.bram_tp, bus.bram_addr, bus.bram_wr_be, bus.bram_wr_data,
             bus.bram_tag, bus.bram_reqid, bus.bram_tlpwr};
      obs_q.push_back(mon);
    end
  end

  function automatic out_t mk(input logic [1:0] tp, input logic [9:0] addr,
                              input logic [3:0] be, input logic [31:0] data,
                              input logic [7:0] tag, input logic [15:0] reqid,
                              input logic tlpwr);
    out_t r;
    r = {tp, addr, be, data, tag, reqid, tlpwr};
    return r;
  endfunction

  task automatic idle_inputs();
    bus.tlp_req_valid = 0; bus.tlp_req_wr = 0; bus.tlp_req_addr = '0;
    bus.tlp_req_be = '0; bus.tlp_req_data = '0; bus.tlp_req_tag = '0;
    bus.tlp_req_reqid = '0;
    bus.usb_req_valid = 0; bus.usb_req_wr = 0; bus.usb_req_addr_lo = 0;
    bus.usb_req_addr = '0; bus.usb_req_be = '0; bus.usb_req_data = '0;
    bus.int_req_valid = 0; bus.int_req_wr = 0; bus.int_req_addr = '0;
    bus.int_req_be = '0; bus.int_req_data = '0;
  endtask

  task automatic test_reset();
    out_t o;
    idle_inputs();
    bus.cfgtlp_wren   = 1;
    rst               = 1;
    bus.int_req_valid = 1;
    bus.int_req_addr  = 10'h003;
    repeat (3) @(posedge clk_pcie);
    @(negedge clk_pcie);
    o = {bus.bram_tp, bus.bram_addr, bus.bram_wr_be, bus.bram_wr_data,
         bus.bram_tag, bus.bram_reqid, bus.bram_tlpwr};
    checks++;
    if (o === '0) passed++;
    else $display("FAIL reset_outputs got=%h exp=0", o);
    checks++;
    if ({bus.tlp_ovf, bus.usb_ovf} === 2'b00) passed++;
    else $display("FAIL reset_ovf got=%b exp=00", {bus.tlp_ovf, bus.usb_ovf});
    checks++;
    if (bus.int_req_ready === 1'b0) passed++;
    else $display("FAIL reset_int_ready got=%b exp=0", bus.int_req_ready);
    @(posedge clk_pcie); #1;
    rst = 0;
    idle_inputs();
    repeat (2) @(posedge clk_pcie);
    obs_q.delete();
  endtask

  task automatic test_tlp_read();
    out_t o, e;
    int   n;
    @(posedge clk_pcie); #1;
    bus.tlp_req_valid = 1; bus.tlp_req_wr = 0; bus.tlp_req_addr = 10'h004;
    bus.tlp_req_be = 4'hF; bus.tlp_req_data = 32'h0; bus.tlp_req_tag = 8'h12;
    bus.tlp_req_reqid = 16'hABCD;
    exp_q.push_back(mk(SRC_TLP, 10'h004, 4'h0, 32'h0, 8'h12, 16'hABCD, 1'b0));
    @(posedge clk_pcie); #1;
    bus.tlp_req_valid = 0;
    @(negedge clk_pcie);
    checks++;
    if (bus.bram_tp === SRC_IDLE) passed++;
    else $display("FAIL tlp_read_early got=%b exp=00", bus.bram_tp);
    @(posedge clk_pcie);
    @(negedge clk_pcie);
    o = {bus.bram_tp, bus.bram_addr, bus.bram_wr_be, bus.bram_wr_data,
         bus.bram_tag, bus.bram_reqid, bus.bram_tlpwr};
    e = mk(SRC_TLP, 10'h004, 4'h0, 32'h0, 8'h12, 16'hABCD, 1'b0);
    checks++;
    if (o === e) passed++;
    else $display("FAIL tlp_read_t2 got=%h exp=%h", o, e);
    while (exp_q.size() > 0) begin
      n = 0;
      while (obs_q.size() == 0 && n < 50) begin @(negedge clk_pcie); n++; end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL tlp_read_sb got=timeout exp=%h", e);
      else begin
        o = obs_q.pop_front();
        if (o === e) passed++;
        else $display("FAIL tlp_read_sb got=%h exp=%h", o, e);
      end
    end
    repeat (4) @(negedge clk_pcie);
    checks++;
    if (obs_q.size() == 0) passed++;
    else $display("FAIL tlp_read_extra got=%0d exp=0", obs_q.size());
    obs_q.delete();
  endtask

  task automatic test_collision();
    out_t o, e;
    int   n;
    @(posedge clk_pcie); #1;
    bus.cfgtlp_wren = 0;
    bus.tlp_req_valid = 1; bus.tlp_req_wr = 1; bus.tlp_req_addr = 10'h010;
    bus.tlp_req_be = 4'hF; bus.tlp_req_data = 32'h1111_2222;
    bus.tlp_req_tag = 8'h21; bus.tlp_req_reqid = 16'h1234;
    bus.usb_req_valid = 1; bus.usb_req_wr = 1; bus.usb_req_addr = 10'h020;
    bus.usb_req_be = 4'hF; bus.usb_req_data = 32'h3333_4444; bus.usb_req_addr_lo = 1;
    exp_q.push_back(mk(SRC_TLP, 10'h010, 4'h0, 32'h1111_2222, 8'h21, 16'h1234, 1'b1));
    exp_q.push_back(mk(SRC_USB, 10'h020, 4'hF, 32'h3333_4444, 8'h01, 16'h0000, 1'b0));
    @(posedge clk_pcie); #1;
    idle_inputs();
    @(posedge clk_pcie);
    @(negedge clk_pcie);
    checks++;
    if ({bus.bram_tp, bus.bram_wr_be, bus.bram_tlpwr} === {SRC_TLP, 4'h0, 1'b1}) passed++;
    else $display("FAIL collide_t2 got=%b/%h/%b exp=01/0/1", bus.bram_tp, bus.bram_wr_be, bus.bram_tlpwr);
    @(posedge clk_pcie); #1;
    bus.cfgtlp_wren = 1;
    @(negedge clk_pcie);
    checks++;
    if ({bus.bram_tp, bus.bram_wr_be} === {SRC_USB, 4'hF}) passed++;
    else $display("FAIL collide_t3 got=%b/%h exp=10/f", bus.bram_tp, bus.bram_wr_be);
    while (exp_q.size() > 0) begin
      n = 0;
      while (obs_q.size() == 0 && n < 50) begin @(negedge clk_pcie); n++; end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL collide_sb got=timeout exp=%h", e);
      else begin
        o = obs_q.pop_front();
        if (o === e) passed++;
        else $display("FAIL collide_sb got=%h exp=%h", o, e);
      end
    end
    repeat (4) @(negedge clk_pcie);
    checks++;
    if (obs_q.size() == 0 && {bus.tlp_ovf, bus.usb_ovf} === 2'b00) passed++;
    else $display("FAIL collide_extra got=%0d/%b%b exp=0/00", obs_q.size(), bus.tlp_ovf, bus.usb_ovf);
    obs_q.delete();
  endtask

  task automatic test_int_hazard();
    out_t o, e;
    int   n;
    @(posedge clk_pcie); #1;
    bus.int_req_valid = 1; bus.int_req_wr = 1; bus.int_req_addr = 10'h030;
    bus.int_req_be = 4'h3; bus.int_req_data = 32'hCAFE_0030;
    exp_q.push_back(mk(SRC_INT, 10'h030, 4'h3, 32'hCAFE_0030, 8'h00, 16'h0000, 1'b0));
    @(negedge clk_pcie);
    checks++;
    if (bus.int_req_ready === 1'b1) passed++;
    else $display("FAIL int_ready_wr got=%b exp=1", bus.int_req_ready);
    @(posedge clk_pcie); #1;
    bus.int_req_wr = 0; bus.int_req_be = 4'hF; bus.int_req_data = 32'h0;
    exp_q.push_back(mk(SRC_INT, 10'h030, 4'h0, 32'h0, 8'h00, 16'h0000, 1'b0));
    @(negedge clk_pcie);
    checks++;
    if ({bus.bram_tp, bus.bram_wr_be, bus.bram_addr, bus.int_req_ready} === {SRC_INT, 4'h3, 10'h030, 1'b0}) passed++;
    else $display("FAIL int_write_out got=%b/%h/%h/%b exp=11/3/030/0", bus.bram_tp, bus.bram_wr_be, bus.bram_addr, bus.int_req_ready);
    @(posedge clk_pcie); #1;
    @(negedge clk_pcie);
    checks++;
    if ({bus.bram_tp, bus.bram_wr_be, bus.int_req_ready} === {SRC_IDLE, 4'h0, 1'b1}) passed++;
    else $display("FAIL int_bubble got=%b/%h/%b exp=00/0/1", bus.bram_tp, bus.bram_wr_be, bus.int_req_ready);
    @(posedge clk_pcie); #1;
    bus.int_req_valid = 0;
    @(negedge clk_pcie);
    checks++;
    if ({bus.bram_tp, bus.bram_wr_be, bus.bram_addr} === {SRC_INT, 4'h0, 10'h030}) passed++;
    else $display("FAIL int_read_out got=%b/%h/%h exp=11/0/030", bus.bram_tp, bus.bram_wr_be, bus.bram_addr);
    while (exp_q.size() > 0) begin
      n = 0;
      while (obs_q.size() == 0 && n < 50) begin @(negedge clk_pcie); n++; end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL int_hazard_sb got=timeout exp=%h", e);
      else begin
        o = obs_q.pop_front();
        if (o === e) passed++;
        else $display("FAIL int_hazard_sb got=%h exp=%h", o, e);
      end
    end
    repeat (4) @(negedge clk_pcie);
    checks++;
    if (obs_q.size() == 0) passed++;
    else $display("FAIL int_hazard_extra got=%0d exp=0", obs_q.size());
    idle_inputs();
    obs_q.delete();
  endtask

  task automatic test_starvation();
    out_t o, e, e_int;
    int   n, int_seen, waited;
    logic got;
    e_int = mk(SRC_INT, 10'h3F0, 4'h0, 32'h0, 8'h00, 16'h0000, 1'b0);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk_pcie); #1;
          bus.usb_req_valid = 1; bus.usb_req_wr = 0; bus.usb_req_be = 4'hF;
          bus.usb_req_addr = 10'h100 + 10'(i); bus.usb_req_data = 32'(i);
          bus.usb_req_addr_lo = 1'(i);
          exp_q.push_back(mk(SRC_USB, 10'h100 + 10'(i), 4'h0, 32'(i),
                             {7'h00, 1'(i)}, 16'h0000, 1'b0));
        end
        @(posedge clk_pcie); #1;
        bus.usb_req_valid = 0;
      end
      begin
        repeat (2) @(posedge clk_pcie);
        #1;
        bus.int_req_valid = 1; bus.int_req_wr = 0; bus.int_req_addr = 10'h3F0;
        bus.int_req_be = 4'h0; bus.int_req_data = 32'h0;
        for (int r = 0; r < 2; r++) begin
          waited = 0;
          got    = 0;
          while (!got && waited <= 40) begin
            @(negedge clk_pcie);
            if (bus.int_req_ready) got = 1;
            else waited++;
          end
          checks++;
          if (got && waited == 15) passed++;
          else $display("FAIL starve_wait%0d got=%0d exp=15", r, waited);
          @(posedge clk_pcie); #1;
        end
        bus.int_req_valid = 0;
      end
    join
    int_seen = 0;
    n        = 0;
    while ((exp_q.size() > 0 || int_seen < 2) && n < 200) begin
      if (obs_q.size() == 0) begin
        @(negedge clk_pcie);
        n++;
      end else begin
        o = obs_q.pop_front();
        checks++;
        if (o.tp == SRC_INT) begin
          int_seen++;
          if (o === e_int) passed++;
          else $display("FAIL starve_int_out got=%h exp=%h", o, e_int);
        end else if (exp_q.size() == 0) begin
          $display("FAIL starve_usb_sb got=%h exp=none", o);
        end else begin
          e = exp_q.pop_front();
          if (o === e) passed++;
          else $display("FAIL starve_usb_sb got=%h exp=%h", o, e);
        end
      end
    end
    repeat (4) @(negedge clk_pcie);
    checks++;
    if (exp_q.size() == 0 && int_seen == 2 && obs_q.size() == 0 && bus.usb_ovf === 1'b0) passed++;
    else $display("FAIL starve_drain got=%0d/%0d/%0d/%b exp=0/2/0/0", exp_q.size(), int_seen, obs_q.size(), bus.usb_ovf);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_usb_overflow();
    out_t o, e;
    out_t usb_exp[$];
    int   n;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_pcie); #1;
      bus.tlp_req_valid = 1; bus.tlp_req_wr = 0; bus.tlp_req_be = 4'h0;
      bus.tlp_req_addr = 10'h080 + 10'(k); bus.tlp_req_data = 32'hA000_0000 + 32'(k);
      bus.tlp_req_tag = 8'(k); bus.tlp_req_reqid = 16'h5A00 + 16'(k);
      exp_q.push_back(mk(SRC_TLP, 10'h080 + 10'(k), 4'h0, 32'hA000_0000 + 32'(k),
                         8'(k), 16'h5A00 + 16'(k), 1'b0));
      if (k >= 1 && k <= 5) begin
        bus.usb_req_valid = 1; bus.usb_req_wr = 1; bus.usb_req_be = 4'h5;
        bus.usb_req_addr = 10'h0C0 + 10'(k); bus.usb_req_data = 32'hB000_0000 + 32'(k);
        bus.usb_req_addr_lo = 1'(k);
        if (k <= 4)
          usb_exp.push_back(mk(SRC_USB, 10'h0C0 + 10'(k), 4'h5, 32'hB000_0000 + 32'(k),
                               {7'h00, 1'(k)}, 16'h0000, 1'b0));
      end else begin
        bus.usb_req_valid = 0;
      end
      @(negedge clk_pcie);
      if (k == 5) begin
        checks++;
        if (bus.usb_ovf === 1'b0) passed++;
        else $display("FAIL usb_ovf_early got=%b exp=0", bus.usb_ovf);
      end
      if (k == 7) begin
        checks++;
        if (bus.usb_ovf === 1'b1) passed++;
        else $display("FAIL usb_ovf_set got=%b exp=1", bus.usb_ovf);
      end
    end
    @(posedge clk_pcie); #1;
    idle_inputs();
    while (usb_exp.size() > 0) exp_q.push_back(usb_exp.pop_front());
    while (exp_q.size() > 0) begin
      n = 0;
      while (obs_q.size() == 0 && n < 50) begin @(negedge clk_pcie); n++; end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL ovf_sb got=timeout exp=%h", e);
      else begin
        o = obs_q.pop_front();
        if (o === e) passed++;
        else $display("FAIL ovf_sb got=%h exp=%h", o, e);
      end
    end
    repeat (4) @(negedge clk_pcie);
    checks++;
    if (obs_q.size() == 0 && {bus.tlp_ovf, bus.usb_ovf} === 2'b01) passed++;
    else $display("FAIL ovf_extra got=%0d/%b%b exp=0/01", obs_q.size(), bus.tlp_ovf, bus.usb_ovf);
    obs_q.delete();
  endtask

  task automatic test_reset_flush();
    out_t o, e;
    int   n;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk_pcie); #1;
      bus.tlp_req_valid = (k <= 5);
      bus.tlp_req_wr = 0; bus.tlp_req_be = 4'h0;
      bus.tlp_req_addr = 10'h200 + 10'(k); bus.tlp_req_data = 32'hD000_0000 + 32'(k);
      bus.tlp_req_tag = 8'h40 + 8'(k); bus.tlp_req_reqid = 16'h7700;
      if (k <= 4)
        exp_q.push_back(mk(SRC_TLP, 10'h200 + 10'(k), 4'h0, 32'hD000_0000 + 32'(k),
                           8'h40 + 8'(k), 16'h7700, 1'b0));
      bus.usb_req_valid = (k >= 1 && k <= 3);
      bus.usb_req_wr = 1; bus.usb_req_be = 4'hC;
      bus.usb_req_addr = 10'h2C0 + 10'(k); bus.usb_req_data = 32'hE000_0000 + 32'(k);
      rst = (k == 6);
    end
    @(posedge clk_pcie); #1;
    rst = 0;
    idle_inputs();
    @(negedge clk_pcie);
    checks++;
    if ({bus.bram_tp, bus.bram_wr_be, bus.tlp_ovf, bus.usb_ovf} === {SRC_IDLE, 4'h0, 2'b00}) passed++;
    else $display("FAIL flush_after_rst got=%b/%h/%b%b exp=00/0/00", bus.bram_tp, bus.bram_wr_be, bus.tlp_ovf, bus.usb_ovf);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL flush_sb got=none exp=%h", e);
      else begin
        o = obs_q.pop_front();
        if (o === e) passed++;
        else $display("FAIL flush_sb got=%h exp=%h", o, e);
      end
    end
    n = 0;
    while (n < 12) begin @(negedge clk_pcie); n++; end
    checks++;
    if (obs_q.size() == 0) passed++;
    else $display("FAIL flush_stale got=%0d exp=0", obs_q.size());
    obs_q.delete();
  endtask

  initial begin
    idle_inputs();
    bus.cfgtlp_wren = 1;
    test_reset();
    test_tlp_read();
    test_collision();
    test_int_hazard();
    test_starvation();
    test_usb_overflow();
    test_reset_flush();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pcileech_cfgspace_arbiter.md
# pcileech_cfgspace_arbiter

Single-clock request arbiter and scheduler for the 4 kB shadow configuration-space BRAM port (`pcileech_mem_wrap` request side). It queues requests from three requesters: PCIe CfgRd/CfgWr TLPs, USB shadow accesses from the CDC FIFO, and an internal requester. It grants at most one request per cycle, so no request is discarded on collision. It also inserts a bubble whenever a request would hit the read-modify-write hazard of the BRAM write path.

## Interface
Parameters:
- `TLP_DEPTH`, default 2: TLP queue entries (power of 2, ≥2).
- `USB_DEPTH`, default 4: USB queue entries (power of 2, ≥2).
- `STARVE_MAX`, default 15: wait cycles after which the internal requester is promoted above USB (4-bit age counter).

Ports:
- `clk_pcie` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfgtlp_wren` in 1: 0 forces BE to 4'b0000 on issued TLP writes; the completion is still generated.
- `tlp_req_valid`, `tlp_req_wr` in 1: TLP request strobe and write flag. No backpressure.
- `tlp_req_addr` in 10, `tlp_req_be` in 4, `tlp_req_data` in 32, `tlp_req_tag` in 8, `tlp_req_reqid` in 16: TLP request fields.
- `usb_req_valid`, `usb_req_wr`, `usb_req_addr_lo` in 1: USB request strobe, write flag and address low bit. No backpressure.
- `usb_req_addr` in 10, `usb_req_be` in 4, `usb_req_data` in 32: USB request fields.
- `int_req_valid` in 1, `int_req_ready` out 1: internal valid/ready handshake.
- `int_req_wr` in 1, `int_req_addr` in 10, `int_req_be` in 4, `int_req_data` in 32: internal request fields.
- `bram_addr` out 10, `bram_wr_be` out 4, `bram_wr_data` out 32: issued BRAM request.
- `bram_tag` out 8, `bram_tp` out 2, `bram_reqid` out 16, `bram_tlpwr` out 1: issued request metadata.
- `tlp_ovf`, `usb_ovf` out 1: sticky queue-overflow flags.

## Operation
- Source types: IDLE=00, TLP=01, USB=10, INT=11.
- Each issued request drives `bram_tp` with its source type.
- TLP and USB requests are pushed into their own FIFO queues.
- A push is accepted when the queue is not full, or when it is full and that queue pops in the same cycle.
- A push to a full queue with no pop is dropped and sets the matching `*_ovf` flag. The flag stays set until reset.
- Candidate selection, evaluated each cycle:
  1. TLP queue head, if the queue is non-empty.
  2. INT, if `int_req_valid` and `int_age ≥ STARVE_MAX`.
  3. USB queue head, if the queue is non-empty.
  4. INT, if `int_req_valid`.
  5. None.
- `int_age` counts cycles while `int_req_valid` is high and `int_req_ready` is low. It saturates at 15 and clears on INT grant or when valid is low.
- Hazard check: the candidate stalls when the output register currently holds a write with `bram_wr_be != 0`, the candidate's `addr` equals `bram_addr`, and the candidate is either a read or a write.
- On a stall, the next output is a bubble: `bram_tp`=IDLE, `bram_wr_be`=0. No queue pops, `int_req_ready`=0, and the candidate is re-evaluated next cycle.
- Grant actions: the granted queue pops, or `int_req_ready`=1 combinationally in the same cycle.
- The output register loads these field mappings on grant:
  - TLP: `tag`/`reqid` pass through. `bram_tlpwr`=`wr`. `be` = `wr&cfgtlp_wren ? be : 0`.
  - USB: `bram_tag` = {7'h0, `addr_lo`}. `bram_reqid` = 0. `be` = `wr ? be : 0`. `bram_tlpwr` = 0.
  - INT: `bram_tag` = 0, `bram_reqid` = 0, `be` = `wr ? be : 0`, `bram_tlpwr` = 0.
- When nothing is granted, the output register loads the bubble.
- Write data is passed unmodified; write masking is done downstream.

## Timing
- All outputs are registered. Reset value of all of them (`bram_*`, `tlp_ovf`, `usb_ovf`) is 0, i.e. `bram_tp`=IDLE. The exception is `int_req_ready`, which is combinational and is 0 while `rst` is high.
- TLP/USB latency: a push at cycle t with an empty queue gives the earliest grant at t+1 and the earliest output at t+2.
- INT latency: handshake at cycle t, output at t+1.
- Throughput: one grant per cycle. Back-to-back accesses to the same address after a write cost one bubble.
- Reset at any point flushes both queues, clears `int_age`, both ovf flags and the output register, and drops all in-flight queued requests.

## Structure
- Package `pcileech_cfgspace_arb_pkg`: source-type constants (IDLE/TLP/USB/INT) and typedef `cfgarb_req_t` with fields wr, addr[9:0], be[3:0], data[31:0], tag[7:0], reqid[15:0].
- Sub-module `pcileech_cfgspace_req_fifo`:
  - parameter DEPTH; ports push/pop/full/empty/head of type `cfgarb_req_t`.
  - Instantiated once for the TLP queue and once for the USB queue.
- Top level contains only the selection logic, hazard compare, age counter and output register.

## Test plan
- Single TLP read addr 0x004 tag 0x12 reqid 0xABCD at t → at t+2: `bram_tp`=01, `bram_addr`=0x004, `bram_tag`=0x12, `bram_reqid`=0xABCD, `bram_tlpwr`=0.
- TLP write addr 0x010 BE 1111 and USB write addr 0x020 at same t, `cfgtlp_wren`=0 → t+2: TLP issued with BE 0000 and `bram_tlpwr`=1. t+3: USB write issued. Nothing dropped.
- INT write addr 0x030 BE 0011 granted, INT read addr 0x030 valid next → output sequence: write, IDLE bubble, read.
- USB queue fed with a USB request every cycle and INT held valid → INT granted no later than 16 cycles after valid rises; `int_age` resets afterwards.
- 5 USB pushes in 5 consecutive cycles while TLP traffic occupies every grant → 4 queued, `usb_ovf`=1. After TLP traffic stops, exactly 4 USB outputs appear in order.
- `rst` asserted with 3 queued USB entries → next cycle: `bram_tp`=IDLE, ovf flags 0, and no stale USB outputs after deassert.
